inst_fetch_unit: RTL

- Initiator side of the instruction-memory read interface. Owns the PC and drives the word address into InstMem.
- Captures the returned instruction into the IF/ID pipeline register.
- Handles stall, branch redirect and HALT detection.
- Sits between InstMem and the decode stage of the 16-bit pipelined CPU.

---
 rtl/inst_fetch_unit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: instruction-fetch stage of the 16-bit pipelined CPU.
// Owns the PC, drives the word address into InstMem, and captures the
// returned instruction into the IF/ID register. It also handles stall,
// branch redirect and HALT detection.
// Optional feature macro: FETCH_PERF_CNT_EN adds the fetch_cnt and
// stall_cnt performance counters.
module inst_fetch_unit #(
    parameter int                 ADDR_W   = 16,
    parameter int                 INST_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = 16'h0000,
    parameter logic [3:0]         HALT_OP  = 4'hF
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic [INST_W-1:0] inst_data,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [INST_W-1:0] if_inst,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc_plus2,
    output logic              if_valid,
    output logic              halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_HALT  = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] PC_STEP   = {{(ADDR_W-2){1'b0}}, 2'b10};
    localparam logic [ADDR_W-1:0] EVEN_MASK = {{(ADDR_W-1){1'b1}}, 1'b0};

    state_t              state_r;
    logic [ADDR_W-1:0]   pc_r;
    logic [ADDR_W-1:0]   pc_plus2_s;
    logic [ADDR_W-1:0]   target_s;
    logic                is_halt_s;

    // The address into InstMem is the PC register itself (asynchronous read).
    assign inst_addr = pc_r;

    // Next-PC arithmetic, the even-aligned redirect target, and HALT opcode decode.
    always_comb begin
        pc_plus2_s = pc_r + PC_STEP;
        target_s   = branch_target & EVEN_MASK;
        if (inst_data[INST_W-1 -: 4] == HALT_OP) begin
            is_halt_s = 1'b1;
        end else begin
            is_halt_s = 1'b0;
        end
    end

    // Fetch FSM: PC, IF/ID register and halt flag, with priority reset > branch > stall > fetch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_r        <= RESET_PC;
            state_r     <= ST_FETCH;
            if_inst     <= {INST_W{1'b0}};
            if_pc       <= {ADDR_W{1'b0}};
            if_pc_plus2 <= {ADDR_W{1'b0}};
            if_valid    <= 1'b0;
            halted      <= 1'b0;
        end else if (branch_taken) begin
            // Redirect squashes whatever was fetched this cycle, including a
            // speculative HALT; if_inst/if_pc keep their old contents.
            pc_r     <= target_s;
            if_valid <= 1'b0;
            state_r  <= ST_FETCH;
            halted   <= 1'b0;
        end else if (stall) begin
            // Hold everything; HALT decode is deliberately not evaluated here.
            pc_r    <= pc_r;
            state_r <= state_r;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if_inst     <= inst_data;
                    if_pc       <= pc_r;
                    if_pc_plus2 <= pc_plus2_s;
                    if_valid    <= 1'b1;
                    if (is_halt_s) begin
                        // HALT is delivered downstream once; the PC stays on it.
                        state_r <= ST_HALT;
                        halted  <= 1'b1;
                    end else begin
                        pc_r <= pc_plus2_s;
                    end
                end
                ST_HALT: begin
                    if_valid <= 1'b0;
                    halted   <= 1'b1;
                end
                default: begin
                    pc_r     <= RESET_PC;
                    state_r  <= ST_FETCH;
                    if_valid <= 1'b0;
                    halted   <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic fetch_en_s;
    logic stall_en_s;

    // A new valid instruction is latched only on a plain fetch edge in FETCH.
    always_comb begin
        if (!branch_taken && !stall && (state_r == ST_FETCH)) begin
            fetch_en_s = 1'b1;
        end else begin
            fetch_en_s = 1'b0;
        end
        stall_en_s = stall;
    end

    // Performance counters: cleared on reset, free-running wrap at 2^32.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_cnt <= 32'd0;
            stall_cnt <= 32'd0;
        end else begin
            if (fetch_en_s) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (stall_en_s) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
